// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bus arbiter slice.
// Holds the arbiter state encoding, the default parameter values used by the
// top level, and a small index helper shared with the round-robin picker.
package spi_pkg;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_DATA_W         = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_CS_GAP         = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SEND,
    ST_WAIT_RX,
    ST_GAP
  } arbState_t;

  // Wraps an index that may have run past the end of an n-entry ring by less
  // than one full turn, which keeps the picker free of a general modulo.
  function automatic int wrapIdx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Round-robin priority picker for the SPI bus arbiter.
// Ports:
//   i_req      - request vector, one bit per requester
//   i_startIdx - requester index that has highest priority this round
//   o_grant    - one-hot grant (all zero when nothing is requesting)
// Purely combinational; the caller owns the pointer state.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_startIdx,
  output logic [N_REQ-1:0] o_grant
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Walk the ring starting at the pointer and grant the first active request;
  // once a winner is found the remaining positions are ignored.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = IDX_W'(wrapIdx(int'(i_startIdx) + i, N_REQ));
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// SPI bus arbiter: shares one SPI master between N_REQ requesters, each of
// which owns one active-low chip select.
// Ports:
//   sys_clk, sys_rst            - clock, asynchronous active-high reset
//   req_valid/req_data/req_last - per-requester TX word offer (data packed
//                                 at [i*DATA_W +: DATA_W])
//   req_ready                   - one-hot word accept back to the owner
//   rsp_valid/rsp_data/rsp_err  - one-cycle response strobe to the owner,
//                                 shared RX word, timeout-abort flag
//   m_valid/m_data/m_ready      - word handshake towards the SPI master
//   m_rx_valid/m_rx_data        - RX word strobe from the SPI master
//   cs_n                        - chip selects, at most one low at a time
// A burst is granted round-robin, holds its chip select across all of its
// words, and is always followed by CS_GAP cycles with every select high.
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CS_GAP         = DEF_CS_GAP
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    m_valid,
  output logic [DATA_W-1:0]       m_data,
  input  logic                    m_ready,
  input  logic                    m_rx_valid,
  input  logic [DATA_W-1:0]       m_rx_data,
  output logic [N_REQ-1:0]        cs_n
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arbState_t         r_state;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_lastOwner;
  logic              r_last;
  logic [WD_W-1:0]   r_wdog;
  logic [GAP_W-1:0]  r_gapCnt;
  logic [N_REQ-1:0]  r_csN;
  logic [N_REQ-1:0]  r_rspValid;
  logic [DATA_W-1:0] r_rspData;
  logic              r_rspErr;

  logic [IDX_W-1:0]  w_startIdx;
  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_winIdx;
  logic [N_REQ-1:0]  w_ownerOH;
  logic [DATA_W-1:0] w_ownerData;
  logic              w_ownerValid;
  logic              w_ownerLast;
  logic              w_inSend;
  logic              w_xfer;
  logic              w_timeout;

  // Priority starts just after whoever owned the bus last, wrapping at the top.
  assign w_startIdx = (r_lastOwner == LAST_IDX) ? '0 : r_lastOwner + IDX_W'(1);

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rrArbiter (
    .i_req     (req_valid),
    .i_startIdx(w_startIdx),
    .o_grant   (w_grant)
  );

  // One-hot grant to index for storing the owner.
  always_comb begin
    w_winIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_winIdx = IDX_W'(i);
      end
    end
  end

  // Select the current owner's TX word out of the packed request bus.
  always_comb begin
    w_ownerData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == r_owner) begin
        w_ownerData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ownerValid = req_valid[r_owner];
  assign w_ownerLast  = req_last[r_owner];
  assign w_ownerOH    = N_REQ'(1) << r_owner;
  assign w_inSend     = (r_state == ST_SEND);
  assign w_xfer       = w_inSend && w_ownerValid && m_ready;
  assign w_timeout    = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // The word handshake is a straight pass-through while sending so the
  // master sees the owner's offer in the same cycle.
  assign m_valid   = w_inSend && w_ownerValid;
  assign m_data    = w_inSend ? w_ownerData : '0;
  assign req_ready = w_xfer ? w_ownerOH : '0;

  assign cs_n      = r_csN;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_err   = r_rspErr;

  // Burst sequencer. The chip select is lowered on the way into GRANT and
  // raised on the way into GAP, so it is a registered output that stays low
  // across every word of a burst. A real RX word beats a watchdog expiry in
  // the same cycle because m_rx_valid is tested first.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_lastOwner <= LAST_IDX;
      r_last      <= 1'b0;
      r_wdog      <= '0;
      r_gapCnt    <= '0;
      r_csN       <= '1;
      r_rspValid  <= '0;
      r_rspData   <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      r_rspValid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_owner <= w_winIdx;
            r_csN   <= ~w_grant;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_last  <= w_ownerLast;
            r_wdog  <= '0;
            r_state <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          if (m_rx_valid) begin
            r_rspValid <= w_ownerOH;
            r_rspData  <= m_rx_data;
            r_rspErr   <= 1'b0;
            if (r_last) begin
              r_csN    <= '1;
              r_gapCnt <= '0;
              r_state  <= ST_GAP;
            end else begin
              r_state  <= ST_SEND;
            end
          end else if (w_timeout) begin
            r_rspValid <= w_ownerOH;
            r_rspData  <= '0;
            r_rspErr   <= 1'b1;
            r_csN      <= '1;
            r_gapCnt   <= '0;
            r_state    <= ST_GAP;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gapCnt == GAP_W'(CS_GAP - 1)) begin
            r_lastOwner <= r_owner;
            r_state     <= ST_IDLE;
          end else begin
            r_gapCnt <= r_gapCnt + GAP_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter. Each requester's pending burst is
// a queue of words; the bench plays both the requesters and the SPI master,
// and predicts the owner of every burst from the round-robin rule.
module tb_spi_bus_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int TMO = 4096;
  localparam int GAP = 2;
  localparam logic [N-1:0] ALL_HIGH = '1;

  logic            sys_clk = 1'b0;
  logic            sys_rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_ready;
  logic            m_rx_valid;
  logic [DW-1:0]   m_rx_data;
  logic [N-1:0]    cs_n;

  int checks   = 0;
  int failures = 0;
  int mdlLastOwner;
  logic [DW-1:0] wordQ [N][$];

  spi_bus_arbiter #(
    .N_REQ(N),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TMO),
    .CS_GAP(GAP)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .m_rx_valid(m_rx_valid),
    .m_rx_data (m_rx_data),
    .cs_n      (cs_n)
  );

  // Free-running 100 MHz system clock.
  always #5 sys_clk = ~sys_clk;

  // One comparison: counted, and reported with tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents the head of every requester's queue on the request bus.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (wordQ[i].size() > 0);
      req_last[i]           = (wordQ[i].size() == 1);
      req_data[i*DW +: DW]  = (wordQ[i].size() > 0) ? wordQ[i][0] : '0;
    end
  endtask

  // Round-robin rule: first requester with work, searching upward from the
  // one after the previous owner and wrapping around.
  function automatic int pickWinner();
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (mdlLastOwner + k) % N;
      if (wordQ[c].size() > 0) return c;
    end
    return -1;
  endfunction

  // Holds reset for a few cycles, checks the idle outputs, then releases.
  task automatic doReset();
    sys_rst    = 1'b1;
    m_ready    = 1'b0;
    m_rx_valid = 1'b0;
    m_rx_data  = '0;
    for (int i = 0; i < N; i++) wordQ[i].delete();
    applyStimulus();
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_cs_n", cs_n, ALL_HIGH);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    sys_rst = 1'b0;
    mdlLastOwner = N - 1;
  endtask

  // Serves the next burst as the SPI master: checks the predicted owner's
  // chip select, accepts each word, answers after rxDelay cycles (or never,
  // when noResp), checks the response strobe and the following gap.
  task automatic serveOne(input int rxDelay, input bit noResp, input bit fixedRx,
                          input logic [DW-1:0] rxFixed, output int owner, output int nRsp);
    int expOwner;
    int cnt;
    bit got;
    bit lastWord;
    logic [N-1:0]  expOH;
    logic [N-1:0]  expCs;
    logic [DW-1:0] rxWord;
    nRsp     = 0;
    expOwner = pickWinner();
    owner    = expOwner;
    if (expOwner < 0) return;
    expOH = '0;
    expOH[expOwner] = 1'b1;
    expCs = ~expOH;

    got = 1'b0;
    for (int w = 0; w < 12 && !got; w++) begin
      @(negedge sys_clk);
      if (cs_n != ALL_HIGH) got = 1'b1;
    end
    checkOutput("grant_seen", got, 1);
    if (!got) return;
    checkOutput("cs_n_grant", cs_n, expCs);

    while (wordQ[expOwner].size() > 0) begin
      got = 1'b0;
      for (int w = 0; w < 12 && !got; w++) begin
        if (m_valid) got = 1'b1;
        else @(negedge sys_clk);
      end
      checkOutput("m_valid_seen", got, 1);
      if (!got) return;
      checkOutput("m_data", m_data, wordQ[expOwner][0]);
      checkOutput("cs_n_send", cs_n, expCs);
      lastWord = (wordQ[expOwner].size() == 1);
      m_ready = 1'b1;
      #1;
      checkOutput("req_ready", req_ready, expOH);
      @(negedge sys_clk);
      m_ready = 1'b0;
      void'(wordQ[expOwner].pop_front());
      applyStimulus();
      cnt = 1;
      if (noResp) begin
        got = 1'b0;
        while (!got && cnt < TMO + 20) begin
          if (rsp_valid != '0) got = 1'b1;
          else begin
            @(negedge sys_clk);
            cnt++;
          end
        end
        checkOutput("timeout_seen", got, 1);
        checkOutput("timeout_latency", cnt - 1, TMO);
        checkOutput("timeout_rsp_valid", rsp_valid, expOH);
        checkOutput("timeout_rsp_err", rsp_err, 1);
        checkOutput("timeout_rsp_data", rsp_data, 0);
        nRsp++;
        wordQ[expOwner].delete();
        applyStimulus();
        lastWord = 1'b1;
      end else begin
        repeat (rxDelay) @(negedge sys_clk);
        checkOutput("rsp_early", rsp_valid, 0);
        rxWord = fixedRx ? rxFixed : DW'($urandom);
        m_rx_valid = 1'b1;
        m_rx_data  = rxWord;
        @(negedge sys_clk);
        m_rx_valid = 1'b0;
        m_rx_data  = DW'($urandom);
        checkOutput("rsp_valid", rsp_valid, expOH);
        checkOutput("rsp_data", rsp_data, rxWord);
        checkOutput("rsp_err", rsp_err, 0);
        nRsp++;
      end
      if (lastWord) begin
        checkOutput("cs_n_gap0", cs_n, ALL_HIGH);
        @(negedge sys_clk);
        checkOutput("cs_n_gap1", cs_n, ALL_HIGH);
        checkOutput("rsp_pulse", rsp_valid, 0);
      end else begin
        checkOutput("cs_n_hold", cs_n, expCs);
      end
    end
    mdlLastOwner = expOwner;
  endtask

  // Directed scenarios followed by randomized bursts.
  initial begin
    int own;
    int nRsp;
    int order [5];
    bit got;
    order = '{0, 1, 2, 3, 0};
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    doReset();

    wordQ[2].push_back(16'h8000);
    applyStimulus();
    serveOne(1, 1'b0, 1'b1, 16'h00E5, own, nRsp);
    checkOutput("single_owner", own, 2);

    m_rx_valid = 1'b1;
    m_rx_data  = 16'h1234;
    @(negedge sys_clk);
    m_rx_valid = 1'b0;
    @(negedge sys_clk);
    checkOutput("stray_rx_ignored", rsp_valid, 0);

    wordQ[1].push_back(16'h2D08);
    wordQ[1].push_back(16'h3100);
    applyStimulus();
    serveOne(2, 1'b0, 1'b0, '0, own, nRsp);
    checkOutput("burst_owner", own, 1);
    checkOutput("burst_rsp_count", nRsp, 2);

    doReset();
    for (int i = 0; i < N; i++) wordQ[i].push_back(DW'($urandom));
    applyStimulus();
    for (int k = 0; k < 5; k++) begin
      serveOne(int'($urandom_range(0, 3)), 1'b0, 1'b0, '0, own, nRsp);
      checkOutput("rr_order", own, order[k]);
      if (own >= 0) wordQ[own].push_back(DW'($urandom));
      applyStimulus();
    end
    for (int i = 0; i < N; i++) wordQ[i].delete();
    applyStimulus();
    repeat (4) @(negedge sys_clk);

    for (int r = 0; r < 5; r++) begin
      int mask;
      mask = int'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          int len;
          len = int'($urandom_range(1, 3));
          for (int j = 0; j < len; j++) wordQ[i].push_back(DW'($urandom));
        end
      end
      applyStimulus();
      for (int s = 0; s < 8 && pickWinner() >= 0; s++) begin
        serveOne(int'($urandom_range(0, 4)), 1'b0, 1'b0, '0, own, nRsp);
      end
    end

    wordQ[1].push_back(DW'($urandom));
    wordQ[2].push_back(DW'($urandom));
    applyStimulus();
    serveOne(0, 1'b1, 1'b0, '0, own, nRsp);
    serveOne(0, 1'b0, 1'b0, '0, own, nRsp);

    wordQ[0].push_back(DW'($urandom));
    applyStimulus();
    serveOne(TMO - 1, 1'b0, 1'b0, '0, own, nRsp);

    wordQ[3].push_back(DW'($urandom));
    applyStimulus();
    got = 1'b0;
    for (int w = 0; w < 12 && !got; w++) begin
      @(negedge sys_clk);
      if (m_valid) got = 1'b1;
    end
    checkOutput("rst_test_send_seen", got, 1);
    m_ready = 1'b1;
    @(negedge sys_clk);
    m_ready = 1'b0;
    void'(wordQ[3].pop_front());
    applyStimulus();
    repeat (3) @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("midrst_cs_n", cs_n, ALL_HIGH);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_m_valid", m_valid, 0);
    m_rx_valid = 1'b1;
    m_rx_data  = 16'hBEEF;
    repeat (2) @(negedge sys_clk);
    checkOutput("midrst_no_rsp", rsp_valid, 0);
    sys_rst    = 1'b0;
    m_rx_valid = 1'b0;
    mdlLastOwner = N - 1;
    @(negedge sys_clk);
    checkOutput("postrst_no_rsp", rsp_valid, 0);
    for (int i = 0; i < N; i++) wordQ[i].push_back(DW'($urandom));
    applyStimulus();
    serveOne(1, 1'b0, 1'b0, '0, own, nRsp);
    checkOutput("postrst_first_owner", own, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8); each owns one chip select.
REQ-002 Parameter DATA_W, default 16: SPI word width.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: maximum sys_clk cycles to wait for a master response.
REQ-004 Parameter CS_GAP, default 2: minimum sys_clk cycles all chip selects stay high between bursts.
REQ-005 One clock, sys_clk; reset is asynchronous and active-high, sys_rst.
REQ-006 sys_clk  in  1  system clock.
REQ-007 sys_rst  in  1  async active-high reset.
REQ-008 req_valid  in  N_REQ  per-requester word valid.
REQ-009 req_data  in  N_REQ*DATA_W  per-requester TX word; requester i occupies slice [i*DATA_W +: DATA_W].
REQ-010 req_last  in  N_REQ  word is the final word of the burst; the chip select is released after it.
REQ-011 req_ready  out  N_REQ  word accepted (one-hot or zero).
REQ-012 rsp_valid  out  N_REQ  one-cycle response strobe to the owning requester.
REQ-013 rsp_data  out  DATA_W  RX word, shared by all requesters; qualified by rsp_valid.
REQ-014 rsp_err  out  1  the response is a timeout abort; qualified by rsp_valid.
REQ-015 m_valid / m_data / m_ready  out/out/in  1/DATA_W/1  word handshake to the SPI master.
REQ-016 m_rx_valid / m_rx_data  in/in  1/DATA_W  one-cycle RX word strobe from the SPI master.
REQ-017 cs_n  out  N_REQ  active-low chip selects; at most one is low at any time.

Function
REQ-018 States: IDLE, GRANT, SEND, WAIT_RX, GAP.
REQ-019 IDLE: when any req_valid is high, pick a winner round-robin starting at (last_owner+1) mod N_REQ and go to GRANT the next cycle.
REQ-020 GRANT: drive cs_n[owner] low, then go to SEND.
REQ-021 SEND: m_valid = req_valid[owner] and m_data = owner slice; req_ready[owner] = m_ready & req_valid[owner] (combinational pass-through). On that transfer, latch req_last and go to WAIT_RX.
REQ-022 WAIT_RX: on m_rx_valid, pulse rsp_valid[owner] with rsp_data = m_rx_data and rsp_err = 0. Then go to GAP if the latched last is 1, otherwise go to SEND and hold cs_n low.
REQ-023 Watchdog counter in WAIT_RX: clears on entry; when it reaches TIMEOUT_CYCLES-1 without m_rx_valid, pulse rsp_valid[owner] with rsp_err = 1 and rsp_data = 0, then go to GAP regardless of last.
REQ-024 m_rx_valid in the same cycle as the timeout: the response wins and no error is reported.
REQ-025 GAP: all cs_n are high for exactly CS_GAP cycles, last_owner <= owner, then go to IDLE.
REQ-026 A requester deasserting req_valid in SEND mid-burst keeps ownership; there is no preemption.
REQ-027 m_rx_valid outside WAIT_RX is ignored; m_valid is 0 outside SEND.
REQ-028 The round-robin pointer wraps N_REQ-1 to 0; a lone requester may win back-to-back, separated by GAP.

Reset
REQ-029 While sys_rst is high: state = IDLE, cs_n = all ones, req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, m_valid = 0, m_data = 0, last_owner = N_REQ-1 (so requester 0 is favoured first), counters = 0.
REQ-030 Reset mid-burst releases cs_n immediately (asynchronously) and produces no response.

Structure
REQ-031 Shared package spi_pkg holds the arbiter state enum and the default-parameter constants.
REQ-032 One sub-module, rr_arbiter (N_REQ-wide round-robin priority pick: request vector plus pointer in, one-hot grant out), is natural; it is combinational and instantiated once.

Verification
REQ-033 Single word: req_valid[2]=1, req_data[2]=16'h8000, last=1, master echoes 16'hE5 -> cs_n=4'b1011 during the transfer, rsp_valid[2] with 16'h00E5, then cs_n=4'b1111 for 2 cycles.
REQ-034 Two-word burst from requester 1 (0x2D08, then 0x3100 with last) -> cs_n[1] stays low across both words, giving 2 rsp_valid[1] pulses and a single GAP.
REQ-035 All 4 requesting continuously with single-word bursts after reset -> grant order 0,1,2,3,0; cs_n never has more than one bit low.
REQ-036 Master never returns m_rx_valid -> exactly 4096 cycles after the transfer, rsp_valid[owner]=1 with rsp_err=1; the next requester is then served.
REQ-037 m_rx_valid coincident with the timeout cycle -> rsp_err=0 with the RX data delivered.
REQ-038 sys_rst asserted in WAIT_RX -> cs_n=all ones in the same cycle, no rsp_valid; after release, requester 0 wins first.
